rgmii_udp_rx: RTL
=================

// Module: rgmii_udp_rx
// PURPOSE
// Receive-side UDP/IPv4/Ethernet frame parser behind the RGMII DDR input stage.
// - Consumes the GMII byte stream: strips preamble/SFD, captures the 42-byte header, filters and streams the UDP payload out as bytes.
// - Checks the FCS and reports per-frame status for the status register (crc_err).
// PARAMETERS
// HEADER_BYTES  42  Ethernet+IPv4+UDP header length; fixed, not overridable
// CHECK_IP_VER  1   1: drop frames unless version_ihl==8'h45
// PORTS
// clk_i               in   1   rx clock (125 MHz GMII byte clock)
// arstn_i             in   1   async active-low reset
// rx_data_i           in   8   GMII rx byte
// rx_valid_i          in   1   rx_dv; low = inter-frame gap
// rx_err_i            in   1   rx_er; marks current frame bad
// check_destination_i in   1   control.check_destination
// fpga_mac_i          in   48  own MAC, network order, byte0 in [47:40]
// fpga_ip_i           in   32  own IP, byte0 in [31:24]
// fpga_port_i         in   16  own UDP port
// m_axis_tdata_o      out  8   payload byte
// m_axis_tvalid_o     out  1   payload valid; no tready, sink must always accept
// m_axis_tlast_o      out  1   last payload byte of frame
// m_axis_tuser_o      out  1   on tlast beat: 1 = frame truncated or rx_err seen
// host_mac_o          out  48  source MAC of last accepted frame
// host_ip_o           out  32  source IP of last accepted frame
// host_port_o         out  16  source UDP port of last accepted frame
// frame_done_o        out  1   1-cycle pulse after rx_valid_i falls on an accepted frame
// crc_err_o           out  1   qualified by frame_done_o: FCS mismatch
// drop_o              out  1   1-cycle pulse when a frame is rejected
// BEHAVIOUR
// Reset: all outputs 0; host_* = 0; FSM in IDLE.
// FSM states:
// - IDLE: first byte with rx_valid_i high: 8'h55 -> PREAMBLE; 8'hD5 -> HEADER; any other -> DROP.
// - PREAMBLE: 8'h55 stay; 8'hD5 (SFD) -> HEADER, clear byte count, CRC <= 32'hFFFF_FFFF; any other -> DROP.
// - HEADER: count 0..41, store each byte in the header register.
//   - Multi-byte fields are network order: length = {byte38, byte39}.
//   - At byte 41 run the filters; on reject -> DROP with drop_o pulse.
//   - Filter: eth_type==16'h0800; protocol==8'h11; udp length>=8; version_ihl==8'h45 if CHECK_IP_VER.
//   - When check_destination_i=1, also require dst MAC == fpga_mac_i or 48'hFFFF_FFFF_FFFF, dst IP == fpga_ip_i, dst port == fpga_port_i.
//   - On pass: latch host_* from the source fields; payload counter = udp_length-8.
//   - Go to PAYLOAD if count!=0, else TAIL.
// - PAYLOAD: each input byte goes out 1 cycle later (registered).
//   - tlast on the byte where the counter reaches 1, then -> TAIL.
// - TAIL: consume padding and FCS until rx_valid_i falls.
// - DROP: ignore bytes until rx_valid_i falls, then -> IDLE.
// Frame end: rx_valid_i falling returns the FSM to IDLE from every state.
// CRC-32:
// - Reflected polynomial 32'hEDB88320, one byte per cycle, over every byte after the SFD including the FCS.
// - Good frame: the final register equals the residue 32'hDEBB20E3; otherwise crc_err_o=1.
// Status pulse: frame_done_o and crc_err_o assert 1 cycle after the rx_valid_i fall, only for frames that passed the filter.
// Truncation: rx_valid_i falls in PAYLOAD before the count ends:
// - Emit one beat next cycle: tvalid=1, tlast=1, tuser=1, tdata=0.
// - frame_done_o follows with crc_err_o=1.
// Truncation in HEADER: treated as DROP (drop_o pulse); no output.
// rx_err_i high at any byte:
// - Before the header completes: frame is dropped.
// - In PAYLOAD: tuser=1 on the tlast beat, and crc_err_o=1.
// Back-to-back frames: one idle cycle between frames is sufficient; no state is carried across frames except host_*.
// Async reset mid-frame: immediate return to IDLE, outputs cleared; the next frame starting with a preamble is parsed normally.
// TESTING
// 1. 7x55,D5, header to own MAC/IP/port, udp len 12, 4 payload bytes 01..04, pad+valid FCS -> 4 beats, tlast on 04, tuser 0; frame_done=1, crc_err=0; host_* latched.
// 2. Same frame with one FCS bit flipped -> payload still streamed; frame_done=1, crc_err=1.
// 3. check_destination_i=1 with dst port != fpga_port_i -> no tvalid; drop_o pulse.
// 4. check_destination_i=1, dst MAC FF..FF, all other fields own -> accepted. eth_type 16'h0806 -> dropped.
// 5. rx_valid_i falls after 2 of 4 payload bytes -> 2 beats, then a tlast/tuser=1 beat with tdata=0; crc_err=1.
// 6. udp len 8 (empty payload) -> no beats; frame_done=1. Then a back-to-back frame with a 1-cycle gap -> parsed correctly.

Source files
------------

// File: rtl/rgmii_udp_rx.sv
// UDP/IPv4/Ethernet receive parser on the GMII byte stream: strips preamble, filters the
// 42-byte header, streams the UDP payload as registered bytes and reports FCS status per frame.
module rgmii_udp_rx #(
   parameter bit CHECK_IP_VER = 1'b1
) (
   input  logic        clk_i,
   input  logic        arstn_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   input  logic        rx_err_i,
   input  logic        check_destination_i,
   input  logic [47:0] fpga_mac_i,
   input  logic [31:0] fpga_ip_i,
   input  logic [15:0] fpga_port_i,
   output logic [7:0]  m_axis_tdata_o,
   output logic        m_axis_tvalid_o,
   output logic        m_axis_tlast_o,
   output logic        m_axis_tuser_o,
   output logic [47:0] host_mac_o,
   output logic [31:0] host_ip_o,
   output logic [15:0] host_port_o,
   output logic        frame_done_o,
   output logic        crc_err_o,
   output logic        drop_o
);
   localparam int          HEADER_BYTES = 42;
   localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_TAIL, S_DROP} state_t;

   state_t      state, state_nx;
   logic [7:0]  hdr [HEADER_BYTES];
   logic [5:0]  byte_cnt;
   logic [15:0] pay_cnt;
   logic [31:0] crc;
   logic        err_seen;

   logic [47:0] dst_mac, src_mac;
   logic [31:0] src_ip, dst_ip;
   logic [15:0] eth_type, src_port, dst_port, udp_len;
   logic [7:0]  ver_ihl, protocol;
   logic        hdr_last, filt_ok, fall;

   logic [7:0]  tdata_nx;
   logic        tvalid_nx, tlast_nx, tuser_nx, done_nx, crc_err_nx, drop_nx;

   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      return c;
   endfunction

   // Byte 41 (UDP checksum) is never inspected, so the filter can run on bytes 0..40 already stored.
   assign dst_mac  = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5]};
   assign src_mac  = {hdr[6], hdr[7], hdr[8], hdr[9], hdr[10], hdr[11]};
   assign eth_type = {hdr[12], hdr[13]};
   assign ver_ihl  = hdr[14];
   assign protocol = hdr[23];
   assign src_ip   = {hdr[26], hdr[27], hdr[28], hdr[29]};
   assign dst_ip   = {hdr[30], hdr[31], hdr[32], hdr[33]};
   assign src_port = {hdr[34], hdr[35]};
   assign dst_port = {hdr[36], hdr[37]};
   assign udp_len  = {hdr[38], hdr[39]};

   assign hdr_last = (state == S_HDR) && rx_valid_i && (byte_cnt == 6'(HEADER_BYTES - 1));
   assign fall     = (state != S_IDLE) && !rx_valid_i;

   assign filt_ok = (eth_type == 16'h0800) && (protocol == 8'h11) && (udp_len >= 16'd8) &&
                    (!CHECK_IP_VER || (ver_ihl == 8'h45)) &&
                    (!check_destination_i ||
                     (((dst_mac == fpga_mac_i) || (dst_mac == 48'hFFFF_FFFF_FFFF)) &&
                      (dst_ip == fpga_ip_i) && (dst_port == fpga_port_i)));

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (fall) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:
               if (rx_valid_i) begin
                  if (rx_err_i)                state_nx = S_DROP;
                  else if (rx_data_i == 8'h55) state_nx = S_PRE;
                  else if (rx_data_i == 8'hD5) state_nx = S_HDR;
                  else                         state_nx = S_DROP;
               end
            S_PRE:
               if (rx_err_i)                state_nx = S_DROP;
               else if (rx_data_i == 8'hD5) state_nx = S_HDR;
               else if (rx_data_i != 8'h55) state_nx = S_DROP;
            S_HDR:
               if (rx_err_i)     state_nx = S_DROP;
               else if (hdr_last) state_nx = !filt_ok ? S_DROP :
                                             (udp_len == 16'd8) ? S_TAIL : S_PAY;
            S_PAY:
               if (pay_cnt == 16'd1) state_nx = S_TAIL;
            default: state_nx = state;
         endcase
      end
   end

   always_comb begin
      tdata_nx   = 8'h00;
      tvalid_nx  = 1'b0;
      tlast_nx   = 1'b0;
      tuser_nx   = 1'b0;
      if (state == S_PAY) begin
         tvalid_nx = 1'b1;
         if (!rx_valid_i) begin
            // truncated payload: close the packet with an empty error beat
            tlast_nx = 1'b1;
            tuser_nx = 1'b1;
         end else begin
            tdata_nx = rx_data_i;
            tlast_nx = (pay_cnt == 16'd1);
            tuser_nx = (pay_cnt == 16'd1) && (err_seen || rx_err_i);
         end
      end
      done_nx    = fall && ((state == S_PAY) || (state == S_TAIL));
      crc_err_nx = done_nx && ((crc != CRC_RESIDUE) || err_seen || (state == S_PAY));
      drop_nx    = ((state_nx == S_DROP) && (state != S_DROP)) ||
                   (fall && ((state == S_PRE) || (state == S_HDR)));
   end

   always_ff @(posedge clk_i) begin
      if ((state == S_HDR) && rx_valid_i && (byte_cnt < 6'(HEADER_BYTES)))
         hdr[byte_cnt] <= rx_data_i;
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         m_axis_tdata_o  <= '0;
         m_axis_tvalid_o <= 1'b0;
         m_axis_tlast_o  <= 1'b0;
         m_axis_tuser_o  <= 1'b0;
         frame_done_o    <= 1'b0;
         crc_err_o       <= 1'b0;
         drop_o          <= 1'b0;
         host_mac_o      <= '0;
         host_ip_o       <= '0;
         host_port_o     <= '0;
         byte_cnt        <= '0;
         pay_cnt         <= '0;
         crc             <= '1;
         err_seen        <= 1'b0;
      end else begin
         m_axis_tdata_o  <= tdata_nx;
         m_axis_tvalid_o <= tvalid_nx;
         m_axis_tlast_o  <= tlast_nx;
         m_axis_tuser_o  <= tuser_nx;
         frame_done_o    <= done_nx;
         crc_err_o       <= crc_err_nx;
         drop_o          <= drop_nx;
         if ((state == S_IDLE) || (state == S_PRE)) begin
            byte_cnt <= '0;
            crc      <= '1;
            err_seen <= 1'b0;
         end else if (rx_valid_i && (state != S_DROP)) begin
            crc <= crc_byte(crc, rx_data_i);
         end
         if ((state == S_HDR) && rx_valid_i)
            byte_cnt <= byte_cnt + 6'd1;
         if (rx_valid_i && rx_err_i && ((state == S_PAY) || (state == S_TAIL)))
            err_seen <= 1'b1;
         if (hdr_last && filt_ok) begin
            host_mac_o  <= src_mac;
            host_ip_o   <= src_ip;
            host_port_o <= src_port;
            pay_cnt     <= udp_len - 16'd8;
         end else if ((state == S_PAY) && rx_valid_i) begin
            pay_cnt <= pay_cnt - 16'd1;
         end
      end
   end

endmodule
